vectorsum_stream_ctrl: RTL and testbench

//  Host-side driver for the vectorsum top. Accepts a valid/ready stream of (x,y) element pairs and

---
 rtl/vectorsum_stream_ctrl_if.sv | 36 +++
 rtl/vectorsum_stream_ctrl.sv | 96 +++++++++
 tb/tb_vectorsum_stream_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/vectorsum_stream_ctrl_if.sv
// vectorsum_stream_ctrl_if: host streams, x/y/z BRAM ports and core start/done for the stream controller.
interface vectorsum_stream_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_x;
    logic [DATA_WIDTH-1:0] in_y;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_z;
    logic                  out_last;
    logic                  busy;
    logic                  start;
    logic                  done;
    logic [DATA_WIDTH-1:0] x_din;
    logic [DATA_WIDTH-1:0] y_din;
    logic [ADDR_WIDTH-1:0] x_wr_addr;
    logic [ADDR_WIDTH-1:0] y_wr_addr;
    logic                  x_wr_en;
    logic                  y_wr_en;
    logic [ADDR_WIDTH-1:0] z_rd_addr;
    logic [DATA_WIDTH-1:0] z_dout;

    modport master (
        input  in_valid, in_x, in_y, out_ready, done, z_dout,
        output in_ready, out_valid, out_z, out_last, busy, start,
               x_din, y_din, x_wr_addr, y_wr_addr, x_wr_en, y_wr_en, z_rd_addr
    );
    modport slave (
        output in_valid, in_x, in_y, out_ready, done, z_dout,
        input  in_ready, out_valid, out_z, out_last, busy, start,
               x_din, y_din, x_wr_addr, y_wr_addr, x_wr_en, y_wr_en, z_rd_addr
    );
endinterface

// File: rtl/vectorsum_stream_ctrl.sv
// vectorsum_stream_ctrl: loads (x,y) pairs into BRAM, runs vectorsum_top once, streams z back out.
module vectorsum_stream_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int VECTOR_SIZE = 1024
) (
    input logic clk,
    input logic rst_n,
    vectorsum_stream_ctrl_if.master bus
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] LAST = CW'(VECTOR_SIZE - 1);
    localparam logic [CW-1:0] VS   = CW'(VECTOR_SIZE);

    typedef enum logic [2:0] {LOAD, FLUSH, START, WAIT, DRAIN} state_t;

    state_t                state, state_nx;
    logic [CW-1:0]         wr_cnt, rd_cnt, tx_cnt;
    logic [DATA_WIDTH-1:0] x_din, y_din;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] fifo [2];
    logic                  wptr, rptr, in_flight;
    logic [1:0]            count;
    logic                  accept, pop, issue, frame_end;

    assign accept    = bus.in_valid && state == LOAD;
    assign pop       = bus.out_valid && bus.out_ready;
    assign frame_end = pop && tx_cnt == LAST;
    // Credit the beat leaving this cycle so a steady drain sustains one beat per cycle.
    assign issue     = state == DRAIN && rd_cnt < VS &&
                       ({1'b0, count} + {2'b0, in_flight} - {2'b0, pop}) < 3'd2;

    assign bus.in_ready  = state == LOAD;
    assign bus.start     = state == START;
    assign bus.busy      = !(state == LOAD && wr_cnt == '0);
    assign bus.out_valid = count != 2'd0;
    assign bus.out_z     = fifo[rptr];
    assign bus.out_last  = bus.out_valid && tx_cnt == LAST;
    assign bus.z_rd_addr = rd_cnt[ADDR_WIDTH-1:0];
    assign bus.x_din     = x_din;
    assign bus.y_din     = y_din;
    assign bus.x_wr_addr = wr_addr;
    assign bus.y_wr_addr = wr_addr;
    assign bus.x_wr_en   = wr_en;
    assign bus.y_wr_en   = wr_en;

    always_comb begin
        state_nx = state;
        case (state)
            LOAD:    state_nx = (accept && wr_cnt == LAST) ? FLUSH : LOAD;
            FLUSH:   state_nx = START;
            START:   state_nx = WAIT;
            WAIT:    state_nx = bus.done ? DRAIN : WAIT;
            DRAIN:   state_nx = frame_end ? LOAD : DRAIN;
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            tx_cnt    <= '0;
            x_din     <= '0;
            y_din     <= '0;
            wr_addr   <= '0;
            wr_en     <= 1'b0;
            fifo[0]   <= '0;
            fifo[1]   <= '0;
            wptr      <= 1'b0;
            rptr      <= 1'b0;
            in_flight <= 1'b0;
            count     <= 2'd0;
        end else begin
            state     <= state_nx;
            wr_en     <= accept;
            if (accept) begin
                x_din   <= bus.in_x;
                y_din   <= bus.in_y;
                wr_addr <= wr_cnt[ADDR_WIDTH-1:0];
            end
            wr_cnt    <= frame_end ? '0 : wr_cnt + CW'(accept);
            rd_cnt    <= frame_end ? '0 : rd_cnt + CW'(issue);
            tx_cnt    <= frame_end ? '0 : tx_cnt + CW'(pop);
            in_flight <= issue;
            if (in_flight) begin
                fifo[wptr] <= bus.z_dout;
                wptr       <= !wptr;
            end
            if (pop) rptr <= !rptr;
            count     <= count + {1'b0, in_flight} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_vectorsum_stream_ctrl.sv
// tb_vectorsum_stream_ctrl: directed frames against a BRAM + adder core model, checked with immediate assertions.
module tb_vectorsum_stream_ctrl;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int VS = 4;

    typedef logic [DW-1:0] vec_t [4];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vectorsum_stream_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) vif ();

    vectorsum_stream_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VECTOR_SIZE(VS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (vif.master)
    );

    logic [DW-1:0] x_mem [16];
    logic [DW-1:0] y_mem [16];
    logic [DW-1:0] z_mem [16];
    int   wr_log [$];
    int   cyc = 0, starts = 0, start_pos = -1, dly = 0, core_delay = 3;
    logic core_done = 1'b0, man_done = 1'b0;
    int   n_chk = 0, n_fail = 0;

    assign vif.done = core_done | man_done;

    // BRAMs with registered z read, plus an adder core that answers start after core_delay cycles.
    always @(posedge clk) begin
        cyc        <= cyc + 1;
        vif.z_dout <= z_mem[vif.z_rd_addr];
        if (vif.x_wr_en) begin
            x_mem[vif.x_wr_addr] <= vif.x_din;
            y_mem[vif.y_wr_addr] <= vif.y_din;
            wr_log.push_back(int'(vif.x_wr_addr));
        end
        core_done <= 1'b0;
        if (vif.start) begin
            starts    <= starts + 1;
            start_pos <= cyc;
            dly       <= core_delay;
        end else if (dly > 0) begin
            dly <= dly - 1;
            if (dly == 1) begin
                for (int i = 0; i < 16; i++) z_mem[i] <= x_mem[i] + y_mem[i];
                core_done <= 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input vec_t xs, input vec_t ys, input bit gaps, output int last_acc);
        for (int i = 0; i < VS; i++) begin
            if (gaps) begin
                @(negedge clk);
                vif.in_valid = 1'b0;
            end
            @(negedge clk);
            check("in_ready_load", vif.in_ready, 1);
            vif.in_valid = 1'b1;
            vif.in_x     = xs[i];
            vif.in_y     = ys[i];
            last_acc     = cyc;
        end
        @(negedge clk);
        vif.in_valid = 1'b0;
    endtask

    task automatic recv(input int n, input bit rnd, input vec_t ez, input string tag);
        int            got = 0;
        int            first = 0;
        logic          held = 1'b0;
        logic          pl = 1'b0;
        logic [DW-1:0] pz = '0;
        for (int k = 0; k < 300 && got < n; k++) begin
            @(negedge clk);
            check({tag, "_busy"}, vif.busy, 1);
            if (held) begin
                check({tag, "_hold_valid"}, vif.out_valid, 1);
                check({tag, "_hold_z"}, vif.out_z, pz);
                check({tag, "_hold_last"}, vif.out_last, pl);
            end
            vif.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (vif.out_valid && vif.out_ready) begin
                check({tag, "_z"}, vif.out_z, ez[got]);
                check({tag, "_last"}, vif.out_last, 64'(got == VS - 1));
                if (got == 0) first = cyc;
                else if (!rnd) check({tag, "_back_to_back"}, cyc, first + got);
                got++;
            end
            held = vif.out_valid && !vif.out_ready;
            pz   = vif.out_z;
            pl   = vif.out_last;
        end
        check({tag, "_beats"}, got, n);
    endtask

    task automatic check_addrs(input int base, input string tag);
        check({tag, "_writes"}, wr_log.size() - base, VS);
        if (wr_log.size() >= base + VS)
            for (int i = 0; i < VS; i++) check({tag, "_addr"}, wr_log[base + i], i);
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        vif.out_ready = 1'b0;
        check({tag, "_idle_busy"}, vif.busy, 0);
        check({tag, "_idle_in_ready"}, vif.in_ready, 1);
        check({tag, "_idle_out_valid"}, vif.out_valid, 0);
    endtask

    initial begin
        vec_t xs, ys, ez;
        int   last_acc, base, s0;
        vif.in_valid  = 1'b0;
        vif.in_x      = '0;
        vif.in_y      = '0;
        vif.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", vif.in_ready, 1);
        check("rst_busy", vif.busy, 0);
        check("rst_start", vif.start, 0);
        check("rst_out_valid", vif.out_valid, 0);
        check("rst_out_z", vif.out_z, 0);
        check("rst_out_last", vif.out_last, 0);
        check("rst_wr_en", {vif.x_wr_en, vif.y_wr_en}, 0);
        check("rst_din", {vif.x_din, vif.y_din}, 0);
        check("rst_rd_addr", vif.z_rd_addr, 0);
        rst_n = 1'b1;

        // Basic frame, full-rate load and drain.
        xs = '{1, 2, 3, 4}; ys = '{10, 20, 30, 40}; ez = '{11, 22, 33, 44};
        base = wr_log.size(); s0 = starts;
        send(xs, ys, 1'b0, last_acc);
        check("t1_flush_in_ready", vif.in_ready, 0);
        check("t1_flush_busy", vif.busy, 1);
        check("t1_flush_wr_en", {vif.x_wr_en, vif.y_wr_en}, 2'b11);
        check("t1_flush_wr_addr", {vif.x_wr_addr, vif.y_wr_addr}, {4'd3, 4'd3});
        check("t1_flush_din", {vif.x_din, vif.y_din}, {32'd4, 32'd40});
        recv(VS, 1'b0, ez, "t1");
        check_idle("t1");
        check_addrs(base, "t1");
        check("t1_start_delay", start_pos - last_acc, 2);
        check("t1_start_count", starts - s0, 1);

        // Gappy load.
        xs = '{5, 6, 7, 8}; ys = '{100, 200, 300, 400}; ez = '{105, 206, 307, 408};
        base = wr_log.size(); s0 = starts;
        send(xs, ys, 1'b1, last_acc);
        recv(VS, 1'b0, ez, "t2");
        check_idle("t2");
        check_addrs(base, "t2");
        check("t2_start_delay", start_pos - last_acc, 2);
        check("t2_start_count", starts - s0, 1);

        // Random downstream backpressure.
        xs = '{7, 0, 32'hFFFF, 3}; ys = '{1, 9, 1, 4}; ez = '{8, 9, 32'h10000, 7};
        send(xs, ys, 1'b0, last_acc);
        recv(VS, 1'b1, ez, "t3");
        check_idle("t3");

        // Stray done in LOAD and stray in_valid in WAIT are ignored.
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        check("t4_done_in_load_ready", vif.in_ready, 1);
        check("t4_done_in_load_busy", vif.busy, 0);
        @(negedge clk);
        check("t4_done_in_load_valid", vif.out_valid, 0);
        core_delay = 10;
        xs = '{2, 4, 6, 8}; ys = '{1, 1, 1, 1}; ez = '{3, 5, 7, 9};
        base = wr_log.size(); s0 = starts;
        send(xs, ys, 1'b0, last_acc);
        @(negedge clk);
        check("t4_start_pulse", vif.start, 1);
        @(negedge clk);
        check("t4_wait_start", vif.start, 0);
        check("t4_wait_in_ready", vif.in_ready, 0);
        vif.in_valid = 1'b1; vif.in_x = 999; vif.in_y = 999;
        repeat (3) @(negedge clk);
        vif.in_valid = 1'b0;
        check("t4_wait_no_write", wr_log.size() - base, VS);
        recv(VS, 1'b0, ez, "t4");
        check_idle("t4");
        check("t4_start_count", starts - s0, 1);
        core_delay = 3;

        // Reset in the middle of DRAIN, then a clean frame.
        xs = '{1, 1, 1, 1}; ys = '{2, 2, 2, 2}; ez = '{3, 3, 3, 3};
        send(xs, ys, 1'b0, last_acc);
        recv(2, 1'b0, ez, "t5a");
        rst_n = 1'b0;
        #1;
        check("t5_rst_in_ready", vif.in_ready, 1);
        check("t5_rst_busy", vif.busy, 0);
        check("t5_rst_out_valid", vif.out_valid, 0);
        check("t5_rst_out_z", vif.out_z, 0);
        check("t5_rst_out_last", vif.out_last, 0);
        vif.out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        xs = '{9, 8, 7, 6}; ys = '{10, 20, 30, 40}; ez = '{19, 28, 37, 46};
        base = wr_log.size();
        send(xs, ys, 1'b0, last_acc);
        recv(VS, 1'b0, ez, "t5b");
        check_idle("t5b");
        check_addrs(base, "t5b");

        // Back-to-back frames at full scale; sums wrap mod 2**32.
        xs = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        ys = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        ez = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE};
        send(xs, ys, 1'b0, last_acc);
        recv(VS, 1'b0, ez, "t6a");
        ys = '{1, 2, 3, 4}; ez = '{0, 1, 2, 3};
        send(xs, ys, 1'b0, last_acc);
        recv(VS, 1'b0, ez, "t6b");
        check_idle("t6b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
